// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: fun3 opcodes,
// FSM state encoding and special-case classification.
package muldiv_sequencer_pkg;

    localparam logic [6:0] MULDIV_FUN7 = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_ZERO,
        SP_DIV0,
        SP_OVF
    } md_special_e;

    function automatic logic signed_rs1(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic signed_rs2(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned one-bit-per-step datapath: shift/add multiply (mode=0) or
// restoring shift/subtract divide (mode=1) over a hi/lo accumulator pair.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            mode,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign sum     = {1'b0, hi_q} + {1'b0, b_q};
    assign shifted = {hi_q, lo_q[XLEN-1]};
    // The remainder is always below the divisor, so the XLEN+1-bit
    // difference has its top bit set exactly when the trial goes negative.
    assign trial   = shifted - {1'b0, b_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = a_in;
            b_d  = b_in;
        end else if (step) begin
            if (!mode) begin
                if (lo_q[0]) begin
                    hi_d = sum[XLEN:1];
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[XLEN-1:1]};
                    lo_d = {hi_q[0], lo_q[XLEN-1:1]};
                end
            end else begin
                if (!trial[XLEN]) begin
                    hi_d = trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shifted[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: FSM, bit counter, sign handling,
// special-case fast path and start/busy/done handshake around muldiv_iter_core.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    md_special_e     special_q, special_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [2:0]      fun3_q, fun3_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    md_special_e     special_in;

    logic            core_load, core_step;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] product, product_neg;
    logic [XLEN-1:0] fix_result;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (core_load),
        .step  (core_step),
        .mode  (fun3_q[2]),
        .a_in  (mag_a),
        .b_in  (mag_b),
        .hi    (core_hi),
        .lo    (core_lo)
    );

    always_comb begin
        neg_a      = signed_rs1(fun3) && rs1[XLEN-1];
        neg_b      = signed_rs2(fun3) && rs2[XLEN-1];
        mag_a      = neg_a ? -rs1 : rs1;
        mag_b      = neg_b ? -rs2 : rs2;
        special_in = SP_NONE;
        if (fun3[2]) begin
            if (rs2 == '0) begin
                special_in = SP_DIV0;
            end else if (signed_rs1(fun3) && (rs1 == INT_MIN) && (rs2 == '1)) begin
                special_in = SP_OVF;
            end
        end else if ((rs1 == '0) || (rs2 == '0)) begin
            special_in = SP_ZERO;
        end
    end

    assign product     = {core_hi, core_lo};
    assign product_neg = -product;

    // fun3 bit 1 separates remainder from quotient among the divide ops.
    always_comb begin
        fix_result = '0;
        case (special_q)
            SP_ZERO: fix_result = '0;
            SP_DIV0: fix_result = fun3_q[1] ? rs1_q : '1;
            SP_OVF:  fix_result = fun3_q[1] ? '0 : rs1_q;
            default: begin
                case (fun3_q)
                    MD_MUL:
                        fix_result = core_lo;
                    MD_MULH, MD_MULHSU, MD_MULHU:
                        fix_result = (sign_a_q ^ sign_b_q) ? product_neg[2*XLEN-1:XLEN] : core_hi;
                    MD_DIV, MD_DIVU:
                        fix_result = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
                    default:
                        fix_result = sign_a_q ? -core_hi : core_hi;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        special_d = special_q;
        counter_d = counter_q;
        fun3_d    = fun3_q;
        rs1_d     = rs1_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    fun3_d    = fun3;
                    rs1_d     = rs1;
                    sign_a_d  = neg_a;
                    sign_b_d  = neg_b;
                    special_d = special_in;
                    counter_d = '0;
                    core_load = 1'b1;
                    state_d   = (special_in == SP_NONE) ? ST_CALC : ST_FIX;
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (counter_q == CNT_LAST) begin
                    counter_d = '0;
                    state_d   = ST_FIX;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                result_d = fix_result;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            result_d  = result_q;
            core_step = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            special_q <= SP_NONE;
            counter_q <= '0;
            fun3_q    <= '0;
            rs1_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            special_q <= special_d;
            counter_q <= counter_d;
            fun3_q    <= fun3_d;
            rs1_q     <= rs1_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed spec cases, hazards
// (start while busy, flush, async reset) and randomized ops vs. a reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  fun3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .fun3   (fun3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Architectural RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f)
            MD_MUL:    begin p = ua * ub; return p[31:0]; end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                p = sa / sb;
                return p[31:0];
            end
            MD_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            MD_REM: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 2;
            if ((f == MD_DIV || f == MD_REM) && a == INT_MIN && b == 32'hFFFF_FFFF) return 2;
            return XLEN + 2;
        end
        if (a == 0 || b == 0) return 2;
        return XLEN + 2;
    endfunction

    // Called at posedge+1 in an IDLE cycle. Counts edges from the start edge
    // (inclusive) to the first edge after which done is seen. poke_at/flush_at
    // inject a stray start or a flush after that many edges (0 = none).
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int poke_at, input int flush_at,
                                 output logic [31:0] res, output int lat, output bit saw_done);
        fun3 = f;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        lat = 0;
        saw_done = 1'b0;
        res = '0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            flush = 1'b0;
            if (done) begin
                saw_done = 1'b1;
                res = result;
                break;
            end
            if (flush_at > 0 && lat == flush_at + 1) break;
            if (lat == poke_at) begin
                start = 1'b1;
                fun3 = MD_MUL;
                rs1 = 32'd5;
                rs2 = 32'd5;
            end
            if (lat == flush_at) flush = 1'b1;
        end
        if (saw_done) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runDirected(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          saw;
        applyStimulus(f, a, b, 0, 0, res, lat, saw);
        checkOutput({tag, "_done"}, 32'(saw), 32'd1);
        checkOutput(tag, res, exp_res);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a, b;
        logic [2:0]  f;
        int          lat;
        bit          saw;

        $display("[TB] reset state");
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        runDirected("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        checkOutput("idle_done_low", 32'(done), 32'd0);
        checkOutput("idle_busy_low", 32'(busy), 32'd0);
        runDirected("mulh_min", MD_MULH, INT_MIN, INT_MIN, 32'h4000_0000, 34);
        runDirected("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        runDirected("mulhsu_m1_2", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
        runDirected("div_m20_3", MD_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
        runDirected("rem_m20_3", MD_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
        runDirected("divu_20_3", MD_DIVU, 32'd20, 32'd3, 32'd6, 34);
        runDirected("remu_20_3", MD_REMU, 32'd20, 32'd3, 32'd2, 34);

        $display("[TB] special cases");
        runDirected("div_by0", MD_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
        runDirected("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5, 2);
        runDirected("div_ovf", MD_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 2);
        runDirected("rem_ovf", MD_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0, 2);
        runDirected("mul_zero", MD_MUL, 32'd0, 32'h1234_5678, 32'd0, 2);

        $display("[TB] start while busy");
        applyStimulus(MD_DIV, 32'hFFFF_FFEC, 32'd3, 10, 0, res, lat, saw);
        checkOutput("poke_done", 32'(saw), 32'd1);
        checkOutput("poke_result", res, 32'hFFFF_FFFA);
        checkOutput("poke_lat", 32'(lat), 32'd34);

        $display("[TB] flush mid-operation");
        runDirected("pre_flush", MD_DIVU, 32'd20, 32'd3, 32'd6, 34);
        applyStimulus(MD_DIV, 32'd100, 32'd7, 0, 20, res, lat, saw);
        checkOutput("flush_no_done", 32'(saw), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_result_held", result, 32'd6);
        runDirected("post_flush", MD_REMU, 32'd20, 32'd3, 32'd2, 34);

        $display("[TB] async reset mid-CALC");
        fun3 = MD_MUL;
        rs1 = 32'd123;
        rs2 = 32'd456;
        start = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("precut_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runDirected("post_reset", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        $display("[TB] randomized back-to-back operations");
        for (int i = 0; i < 1500; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: a = '0;
                1: b = '0;
                2: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
                3: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                4: a = -32'($urandom_range(0, 50));
                default: ;
            endcase
            applyStimulus(f, a, b, 0, 0, res, lat, saw);
            checkOutput($sformatf("rand%0d_f%0d_res", i, f), res, refResult(f, a, b));
            checkOutput($sformatf("rand%0d_f%0d_lat", i, f), saw ? 32'(lat) : 32'hFFFF_FFFF, 32'(refLatency(f, a, b)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
